// File: rtl/reg_scan_pkg.sv
// reg_scan_pkg: shared types and default sizing for the register-file
// debug read-out engine (reg_scan) and its stream interface.
package reg_scan_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_REGBITS = 4;
    localparam int unsigned NUM_REGS    = 1 << DEF_REGBITS;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM,
        DONE
    } state_t;

endpackage

// File: rtl/reg_scan_if.sv
// reg_scan_if: valid/ready word stream carrying captured register words
// (data, index, last marker) from reg_scan to the debug/host link.
interface reg_scan_if
    import reg_scan_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned REGBITS = DEF_REGBITS
);

    logic [WIDTH-1:0]   out_data;
    logic [REGBITS-1:0] out_addr;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport master (
        output out_data,
        output out_addr,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_addr,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reg_scan.sv
// reg_scan: on a start pulse, walks every register-file address on a read
// port, captures each word and streams it out one word per transfer.
// Optional feature macro: REG_SCAN_CHECKSUM_EN appends an XOR checksum word
// (out_addr all-ones, out_last set) after the last register.
module reg_scan
    import reg_scan_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned REGBITS = DEF_REGBITS
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [REGBITS-1:0] rd_addr,
    input  logic [WIDTH-1:0]   rd_data,
    reg_scan_if.master         out_if,
    output logic               busy,
    output logic               done
);

    localparam logic [REGBITS-1:0] LAST_IDX = '1;

    state_t             state, state_n;
    logic [REGBITS-1:0] idx, idx_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic [REGBITS-1:0] addr_q, addr_n;
    logic               valid_q, valid_n;
    logic               last_q, last_n;
`ifdef REG_SCAN_CHECKSUM_EN
    logic [WIDTH-1:0]   acc_q, acc_n;
`endif

    // State, index and output-word registers; reset drops the stream at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef REG_SCAN_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            data_q  <= data_n;
            addr_q  <= addr_n;
            valid_q <= valid_n;
            last_q  <= last_n;
`ifdef REG_SCAN_CHECKSUM_EN
            acc_q   <= acc_n;
`endif
        end
    end

    // Next-state and next-word decode; every register holds unless changed.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data_q;
        addr_n  = addr_q;
        valid_n = valid_q;
        last_n  = last_q;
`ifdef REG_SCAN_CHECKSUM_EN
        acc_n   = acc_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    state_n = FETCH;
`ifdef REG_SCAN_CHECKSUM_EN
                    acc_n   = '0;
`endif
                end
            end
            FETCH: begin
                data_n  = rd_data;
                addr_n  = idx;
                valid_n = 1'b1;
`ifdef REG_SCAN_CHECKSUM_EN
                acc_n   = acc_q ^ rd_data;
                last_n  = 1'b0;
`else
                last_n  = (idx == LAST_IDX);
`endif
                state_n = SEND;
            end
            SEND: begin
                if (out_if.out_ready) begin
                    valid_n = 1'b0;
                    if (idx == LAST_IDX) begin
`ifdef REG_SCAN_CHECKSUM_EN
                        // Checksum word follows the last register with no gap cycle.
                        data_n  = acc_q;
                        addr_n  = '1;
                        last_n  = 1'b1;
                        valid_n = 1'b1;
                        state_n = CSUM;
`else
                        state_n = DONE;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = FETCH;
                    end
                end
            end
`ifdef REG_SCAN_CHECKSUM_EN
            CSUM: begin
                if (out_if.out_ready) begin
                    valid_n = 1'b0;
                    state_n = DONE;
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rd_addr          = idx;
    assign out_if.out_data  = data_q;
    assign out_if.out_addr  = addr_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state == FETCH) || (state == SEND) || (state == CSUM);
    assign done             = (state == DONE);

endmodule
